// File: rtl/reg_load_fifo.sv
// reg_load_fifo: FIFO that buffers producer words and presents them as d_o/ld_o to a downstream register.
// Latency: 1 cycle from accepted rd_i to ld_o=1 with the word on d_o; a write is poppable the cycle after it lands (no fall-through).
// Backpressure: full_o blocks writes unless a pop is accepted that cycle; rejected writes are dropped (flagged on ovf_o when REG_LOAD_FIFO_OVF_EN is defined).
module reg_load_fifo #(
  parameter int lsize      = 8,
  parameter int depth_log2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [lsize-1:0]      d_i,
  input  logic                  wr_i,
  output logic                  full_o,
  input  logic                  rd_i,
  output logic                  empty_o,
  output logic [depth_log2:0]   count_o,
  output logic [lsize-1:0]      d_o,
  output logic                  ld_o
`ifdef REG_LOAD_FIFO_OVF_EN
  ,
  output logic                  ovf_o
`endif
);

  localparam int depth = 1 << depth_log2;

  typedef logic [depth_log2:0]   ptr_t;
  typedef logic [depth_log2-1:0] addr_t;

  // Storage is deliberately not reset; pointer state alone defines validity.
  logic [lsize-1:0] mem [depth];

  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  ptr_t  wr_ptr_nxt;
  ptr_t  rd_ptr_nxt;
  addr_t wr_addr;
  addr_t rd_addr;

  logic rd_accept;
  logic wr_accept;
  logic wr_drop;

  assign wr_addr = wr_ptr[depth_log2-1:0];
  assign rd_addr = rd_ptr[depth_log2-1:0];

  // Status flags are purely combinational from the registered pointers, so
  // they move on the same edge as the pointer update that causes them.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_addr == rd_addr) && (wr_ptr[depth_log2] != rd_ptr[depth_log2]);
  assign count_o = wr_ptr - rd_ptr;

  // Accept decisions and next pointers; a pop frees the slot a same-cycle write needs when full.
  always_comb begin
    rd_accept  = 1'b0;
    wr_accept  = 1'b0;
    wr_drop    = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    rd_accept  = rd_i && !empty_o;
    wr_accept  = wr_i && (!full_o || rd_accept);
    wr_drop    = wr_i && full_o && !rd_accept;
    if (wr_accept) begin
      wr_ptr_nxt = wr_ptr + ptr_t'(1);
    end
    if (rd_accept) begin
      rd_ptr_nxt = rd_ptr + ptr_t'(1);
    end
  end

  // Pointer registers; reset discards anything still queued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Data array write port; gated by reset so a write in the reset cycle has no effect.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_accept) begin
      mem[wr_addr] <= d_i;
    end
  end

  // Registered pop output: d_o holds its last word between pops, ld_o pulses per pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_o  <= '0;
      ld_o <= 1'b0;
    end else begin
      ld_o <= rd_accept;
      if (rd_accept) begin
        d_o <= mem[rd_addr];
      end
    end
  end

`ifdef REG_LOAD_FIFO_OVF_EN
  // Sticky overflow: any write dropped against a full FIFO latches until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
    end else if (wr_drop) begin
      ovf_o <= 1'b1;
    end
  end
`else
  // Without the overflow flag, dropped writes are silent.
  logic unused_drop;
  assign unused_drop = wr_drop;
`endif

endmodule

// File: tb/tb_reg_load_fifo.sv
// tb_reg_load_fifo: directed scoreboard bench for reg_load_fifo (depth 4, lsize 8) plus a downstream register model.
// Latency: checks sample #1 after each rising edge; pops are expected on ld_o the cycle after rd_i.
// Backpressure: model accepts writes only when not full or when a pop is accepted the same cycle.
module tb_reg_load_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] d_i;
  logic       wr_i;
  logic       full_o;
  logic       rd_i;
  logic       empty_o;
  logic [2:0] count_o;
  logic [7:0] d_o;
  logic       ld_o;
`ifdef REG_LOAD_FIFO_OVF_EN
  logic       ovf_o;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] exp_out[$];
  logic [7:0] last_d;
  logic       exp_ovf;

  // Downstream register (register lsize 8)
  logic [7:0] reg_q;

  always #5 clk_i = ~clk_i;

  reg_load_fifo #(.lsize(8), .depth_log2(2)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (d_i),
    .wr_i   (wr_i),
    .full_o (full_o),
    .rd_i   (rd_i),
    .empty_o(empty_o),
    .count_o(count_o),
    .d_o    (d_o),
    .ld_o   (ld_o)
`ifdef REG_LOAD_FIFO_OVF_EN
    ,
    .ovf_o  (ovf_o)
`endif
  );

  // Register downstream of the FIFO: loads d_o whenever ld_o strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) reg_q <= 8'h00;
    else if (ld_o) reg_q <= d_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, advance the model, then compare every output.
  task automatic cyc(input logic rst, input logic wr, input logic [7:0] d, input logic rd, input string tag);
    logic rd_acc;
    logic wr_acc;
    logic [7:0] e;
    rst_i = rst;
    wr_i  = wr;
    d_i   = d;
    rd_i  = rd;
    if (rst) begin
      mq.delete();
      exp_out.delete();
      last_d  = 8'h00;
      exp_ovf = 1'b0;
      rd_acc  = 1'b0;
    end else begin
      rd_acc = rd && (mq.size() > 0);
      wr_acc = wr && ((mq.size() < 4) || rd_acc);
      if (wr && !wr_acc) exp_ovf = 1'b1;
      if (rd_acc) exp_out.push_back(mq.pop_front());
      if (wr_acc) mq.push_back(d);
    end
    @(posedge clk_i);
    #1;
    chk({tag, ".ld"}, ld_o, rd_acc);
    if (rd_acc) begin
      e = exp_out.pop_front();
      last_d = e;
    end
    chk({tag, ".d"}, d_o, last_d);
    chk({tag, ".count"}, count_o, mq.size());
    chk({tag, ".empty"}, empty_o, mq.size() == 0);
    chk({tag, ".full"}, full_o, mq.size() == 4);
`ifdef REG_LOAD_FIFO_OVF_EN
    chk({tag, ".ovf"}, ovf_o, exp_ovf);
`endif
  endtask

  initial begin
    rst_i = 1'b1; wr_i = 1'b0; rd_i = 1'b0; d_i = 8'h00;
    last_d = 8'h00; exp_ovf = 1'b0;

    // Reset with both requests high
    cyc(1, 1, 8'hEE, 1, "rst0");
    cyc(1, 1, 8'hEE, 1, "rst1");
    cyc(0, 0, 8'h00, 0, "idle");

    // Fill then drain
    cyc(0, 1, 8'h11, 0, "fill");
    cyc(0, 1, 8'h22, 0, "fill");
    cyc(0, 1, 8'h33, 0, "fill");
    cyc(0, 1, 8'h44, 0, "fill");
    chk("full_after_fill", full_o, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, "drain");
    cyc(0, 0, 8'h00, 1, "rd_empty");
    cyc(0, 0, 8'h00, 0, "hold");

    // Overflow: write while full without read is dropped
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'h61 + i), 0, "ofill");
    cyc(0, 1, 8'h55, 0, "ovf_wr");
    cyc(0, 0, 8'h00, 0, "ovf_hold");
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, "ovf_drain");
    cyc(0, 0, 8'h00, 0, "ovf_sticky");

    // Reset discards pending words and clears the overflow flag
    cyc(0, 1, 8'h77, 0, "pend");
    cyc(1, 0, 8'h00, 0, "rst2");
    cyc(0, 0, 8'h00, 1, "post_rst");

    // Simultaneous write+read at empty: no fall-through
    cyc(0, 1, 8'hA0, 1, "empty_wr_rd");
    cyc(0, 1, 8'hA1, 0, "fill2");
    cyc(0, 1, 8'hA2, 0, "fill2");
    cyc(0, 1, 8'hA3, 0, "fill2");
    // Simultaneous write+read at full: both accepted
    cyc(0, 1, 8'hB0, 1, "full_wr_rd");
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, "drain2");

    // Wrap: streaming one write and one pop per cycle
    for (int i = 0; i < 20; i++) cyc(0, 1, 8'(i), 1, "wrap");
    cyc(0, 0, 8'h00, 1, "wrap_tail");
    cyc(0, 0, 8'h00, 1, "wrap_empty");

    // Downstream register capture
    cyc(0, 1, 8'h3C, 0, "ds_wr");
    cyc(0, 0, 8'h00, 1, "ds_rd");
    chk("ds_reg_before", reg_q, 8'h13);
    cyc(0, 0, 8'h00, 0, "ds_cap");
    chk("ds_reg_cap", reg_q, 8'h3C);
    cyc(0, 0, 8'h00, 0, "ds_hold");
    chk("ds_reg_hold", reg_q, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
